// File: rtl/xgcd_operand_engine.sv
// Operand banks A/B and result bank R behind an SRAM-style port, APB control/status,
// and a word-serial R[i] = A[i] + B[i] + carry sequencer (LSW first).
module xgcd_operand_engine #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned DEPTH  = 32
) (
    input  logic                CLK,
    input  logic                RESETn,
    input  logic [31:0]         PADDR,
    input  logic                PSEL,
    input  logic                PENABLE,
    input  logic                PWRITE,
    input  logic [31:0]         PWDATA,
    output logic [31:0]         PRDATA,
    output logic                PREADY,
    output logic                PSLVERR,
    input  logic                SRAM_CEn,
    input  logic [31:0]         SRAM_ADDR,
    input  logic [DATA_W-1:0]   SRAM_WDATA,
    input  logic                SRAM_WEn,
    input  logic [DATA_W/8-1:0] SRAM_WBEn,
    output logic [DATA_W-1:0]   SRAM_RDATA,
    output logic                IRQ,
    output logic                START_OUT,
    output logic                DONE_OUT
);
    localparam int unsigned BE_W      = DATA_W / 8;
    localparam int unsigned BE_LG     = $clog2(BE_W);
    localparam int unsigned AW        = $clog2(DEPTH);
    localparam logic [8:0]  DEPTH_LEN = 9'(DEPTH);
    localparam logic [31:0] ID_VALUE  = 32'h5A5A_5A5A;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e            st_q;
    logic [AW-1:0]     idx_q;
    logic              carry_q;
    logic              carry_flag_q;
    logic              done_q;
    logic              irq_en_q;
    logic              err_q;
    logic              start_out_q;
    logic              done_out_q;
    logic [8:0]        len_q;
    logic [31:0]       cycles_q;
    logic [31:0]       prdata_q;
    logic [DATA_W-1:0] sram_rdata_q;

    logic [DATA_W-1:0] mem_a [DEPTH];
    logic [DATA_W-1:0] mem_b [DEPTH];
    logic [DATA_W-1:0] mem_r [DEPTH];

    logic              busy;
    logic              apb_setup;
    logic              start_wr;
    logic [9:0]        reg_idx;
    logic [31:0]       rdata_mux;
    logic [8:0]        eff_len;
    logic              last_word;
    logic [DATA_W:0]   sum;
    logic [3:0]        sram_bank;
    logic [AW-1:0]     sram_word;
    logic              sram_wr;
    logic              sram_rd;
    logic              unused_in;

    // BUSY spans RUN and the single DONE cycle.
    assign busy      = (st_q != StIdle);
    assign apb_setup = PSEL & ~PENABLE;
    assign reg_idx   = PADDR[11:2];
    assign start_wr  = apb_setup & PWRITE & (reg_idx == 10'd1) & PWDATA[0];

    assign PRDATA     = prdata_q;
    assign PREADY     = 1'b1;
    assign PSLVERR    = err_q & PSEL & PENABLE;
    assign SRAM_RDATA = sram_rdata_q;
    assign IRQ        = done_q & irq_en_q;
    assign START_OUT  = start_out_q;
    assign DONE_OUT   = done_out_q;

    assign sram_bank = SRAM_ADDR[11:8];
    assign sram_word = SRAM_ADDR[BE_LG +: AW];
    assign sram_wr   = ~SRAM_CEn & ~SRAM_WEn & ~busy;
    assign sram_rd   = ~SRAM_CEn & SRAM_WEn;

    assign unused_in = ^{PADDR[31:12], PADDR[1:0], PWDATA[31:9], SRAM_ADDR};

    always_comb begin
        eff_len = len_q;
        if (len_q == 9'd0 || len_q > DEPTH_LEN) begin
            eff_len = DEPTH_LEN;
        end
    end

    assign last_word = (9'(idx_q) == eff_len - 9'd1);
    assign sum = {1'b0, mem_a[idx_q]} + {1'b0, mem_b[idx_q]} + {{DATA_W{1'b0}}, carry_q};

    always_comb begin
        rdata_mux = '0;
        case (reg_idx)
            10'd0:   rdata_mux = ID_VALUE;
            10'd1:   rdata_mux = {30'd0, irq_en_q, 1'b0};
            10'd2:   rdata_mux = {29'd0, carry_flag_q, done_q, busy};
            10'd3:   rdata_mux = {23'd0, len_q};
            10'd4:   rdata_mux = cycles_q;
            default: rdata_mux = '0;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            st_q         <= StIdle;
            idx_q        <= '0;
            carry_q      <= 1'b0;
            carry_flag_q <= 1'b0;
            done_q       <= 1'b0;
            irq_en_q     <= 1'b0;
            err_q        <= 1'b0;
            start_out_q  <= 1'b0;
            done_out_q   <= 1'b0;
            len_q        <= '0;
            cycles_q     <= '0;
            prdata_q     <= '0;
        end else begin
            start_out_q <= 1'b0;
            done_out_q  <= 1'b0;
            if (apb_setup) begin
                err_q <= start_wr & busy;
                if (PWRITE) begin
                    case (reg_idx)
                        10'd1:   irq_en_q <= PWDATA[1];
                        10'd2:   if (PWDATA[1]) done_q <= 1'b0;
                        10'd3:   if (!busy) len_q <= PWDATA[8:0];
                        default: ;
                    endcase
                end else begin
                    prdata_q <= rdata_mux;
                end
            end
            // Placed after the W1C so a completing operation wins over a clear.
            case (st_q)
                StIdle: begin
                    if (start_wr) begin
                        st_q        <= StRun;
                        idx_q       <= '0;
                        carry_q     <= 1'b0;
                        cycles_q    <= '0;
                        done_q      <= 1'b0;
                        start_out_q <= 1'b1;
                    end
                end
                StRun: begin
                    carry_q  <= sum[DATA_W];
                    idx_q    <= idx_q + 1'b1;
                    cycles_q <= cycles_q + 32'd1;
                    if (last_word) begin
                        st_q <= StDone;
                    end
                end
                StDone: begin
                    carry_flag_q <= carry_q;
                    done_q       <= 1'b1;
                    done_out_q   <= 1'b1;
                    st_q         <= StIdle;
                end
                default: st_q <= StIdle;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (st_q == StRun) begin
            mem_r[idx_q] <= sum[DATA_W-1:0];
        end
    end

    // Operand writes are locked out while busy so the sequencer sees stable inputs.
    always_ff @(posedge CLK) begin
        if (sram_wr) begin
            for (int b = 0; b < BE_W; b++) begin
                if (!SRAM_WBEn[b]) begin
                    if (sram_bank == 4'd0) mem_a[sram_word][b*8 +: 8] <= SRAM_WDATA[b*8 +: 8];
                    if (sram_bank == 4'd1) mem_b[sram_word][b*8 +: 8] <= SRAM_WDATA[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            sram_rdata_q <= '0;
        end else if (sram_rd) begin
            case (sram_bank)
                4'd0:    sram_rdata_q <= mem_a[sram_word];
                4'd1:    sram_rdata_q <= mem_b[sram_word];
                4'd2:    sram_rdata_q <= mem_r[sram_word];
                default: sram_rdata_q <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_xgcd_operand_engine.sv
// Self-checking bench for xgcd_operand_engine: register table, directed sequences,
// and randomized operand/length runs against a plain-arithmetic bank model.
module tb_xgcd_operand_engine;
    localparam int DATA_W = 64;
    localparam int DEPTH  = 32;

    logic              CLK;
    logic              RESETn;
    logic [31:0]       PADDR;
    logic              PSEL;
    logic              PENABLE;
    logic              PWRITE;
    logic [31:0]       PWDATA;
    logic [31:0]       PRDATA;
    logic              PREADY;
    logic              PSLVERR;
    logic              SRAM_CEn;
    logic [31:0]       SRAM_ADDR;
    logic [DATA_W-1:0] SRAM_WDATA;
    logic              SRAM_WEn;
    logic [7:0]        SRAM_WBEn;
    logic [DATA_W-1:0] SRAM_RDATA;
    logic              IRQ;
    logic              START_OUT;
    logic              DONE_OUT;

    xgcd_operand_engine #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RESETn(RESETn),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PWDATA(PWDATA),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .SRAM_CEn(SRAM_CEn), .SRAM_ADDR(SRAM_ADDR), .SRAM_WDATA(SRAM_WDATA),
        .SRAM_WEn(SRAM_WEn), .SRAM_WBEn(SRAM_WBEn), .SRAM_RDATA(SRAM_RDATA),
        .IRQ(IRQ), .START_OUT(START_OUT), .DONE_OUT(DONE_OUT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_fail   = 0;

    // Bank model
    logic [63:0] ma [DEPTH];
    logic [63:0] mb [DEPTH];
    logic [63:0] mr [DEPTH];
    bit          known [DEPTH];

    // Pulse monitor
    int cyc = 0;
    int start_cnt = 0, done_cnt = 0, start_cyc = 0, done_cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;
    always @(negedge CLK) begin
        if (START_OUT) begin start_cnt++; start_cyc = cyc; end
        if (DONE_OUT)  begin done_cnt++;  done_cyc  = cyc; end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apb_write(input logic [31:0] a, input logic [31:0] d, output logic err);
        @(negedge CLK);
        PADDR = a; PWDATA = d; PWRITE = 1'b1; PSEL = 1'b1; PENABLE = 1'b0;
        @(negedge CLK);
        PENABLE = 1'b1;
        #1 err = PSLVERR;
        @(negedge CLK);
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic apb_read(input logic [31:0] a, output logic [31:0] d);
        @(negedge CLK);
        PADDR = a; PWRITE = 1'b0; PSEL = 1'b1; PENABLE = 1'b0;
        @(negedge CLK);
        PENABLE = 1'b1;
        #1 d = PRDATA;
        @(negedge CLK);
        PSEL = 1'b0; PENABLE = 1'b0;
    endtask

    task automatic sram_write(input int bank, input int word, input logic [63:0] d,
                              input logic [7:0] be_n);
        @(negedge CLK);
        SRAM_CEn = 1'b0; SRAM_WEn = 1'b0; SRAM_ADDR = 32'((bank << 8) | (word << 3));
        SRAM_WDATA = d; SRAM_WBEn = be_n;
        @(negedge CLK);
        SRAM_CEn = 1'b1; SRAM_WEn = 1'b1; SRAM_WBEn = 8'hFF;
    endtask

    task automatic sram_read(input int bank, input int word, output logic [63:0] d);
        @(negedge CLK);
        SRAM_CEn = 1'b0; SRAM_WEn = 1'b1; SRAM_ADDR = 32'((bank << 8) | (word << 3));
        @(negedge CLK);
        SRAM_CEn = 1'b1;
        d = SRAM_RDATA;
    endtask

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d,
                                          input logic [7:0] be_n);
        logic [63:0] r;
        r = old;
        for (int b = 0; b < 8; b++) if (!be_n[b]) r[b*8 +: 8] = d[b*8 +: 8];
        return r;
    endfunction

    // Model write through the SRAM port while idle
    task automatic model_sram_write(input int bank, input int word, input logic [63:0] d,
                                    input logic [7:0] be_n);
        sram_write(bank, word, d, be_n);
        if (bank == 0) ma[word] = merge(ma[word], d, be_n);
        if (bank == 1) mb[word] = merge(mb[word], d, be_n);
    endtask

    function automatic int eff_of(input logic [31:0] len);
        int l;
        l = int'(len[8:0]);
        return (l == 0 || l > DEPTH) ? DEPTH : l;
    endfunction

    function automatic logic model_run(input int eff);
        logic        c;
        logic [64:0] s;
        c = 1'b0;
        for (int i = 0; i < eff; i++) begin
            s = {1'b0, ma[i]} + {1'b0, mb[i]} + 65'(c);
            mr[i] = s[63:0];
            c = s[64];
            known[i] = 1'b1;
        end
        return c;
    endfunction

    task automatic wait_done(input int d0, input string tag);
        int n;
        n = 0;
        while (done_cnt == d0 && n < 2000) begin
            @(posedge CLK);
            n++;
        end
        check({tag, " done_seen"}, 64'(done_cnt != d0), 64'd1);
        @(negedge CLK);
    endtask

    task automatic check_r(input string tag);
        logic [63:0] d;
        for (int i = 0; i < DEPTH; i++) begin
            if (known[i]) begin
                sram_read(2, i, d);
                check($sformatf("%s R[%0d]", tag, i), d, mr[i]);
            end
        end
    endtask

    task automatic do_run(input logic [31:0] len, input logic irq_en, input string tag);
        int          eff, s0, d0;
        logic        c, err;
        logic [31:0] rd;
        eff = eff_of(len);
        c = model_run(eff);
        apb_write(32'h00C, len, err);
        s0 = start_cnt; d0 = done_cnt;
        apb_write(32'h004, {30'd0, irq_en, 1'b1}, err);
        check({tag, " start_pslverr"}, 64'(err), 64'd0);
        wait_done(d0, tag);
        check({tag, " irq"}, 64'(IRQ), 64'(irq_en));
        check({tag, " start_pulses"}, 64'(start_cnt - s0), 64'd1);
        check({tag, " latency"}, 64'(done_cyc - start_cyc), 64'(eff + 1));
        apb_read(32'h008, rd);
        check({tag, " status"}, 64'(rd), 64'({29'd0, c, 1'b1, 1'b0}));
        apb_read(32'h010, rd);
        check({tag, " cycles"}, 64'(rd), 64'(eff));
        check_r(tag);
    endtask

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
        logic [31:0] exp;
    } reg_vec_t;

    initial begin
        reg_vec_t    vecs [14];
        logic        err;
        logic [31:0] rd;
        logic [63:0] d;
        int          s0, d0;

        RESETn = 1'b0; PADDR = '0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0; PWDATA = '0;
        SRAM_CEn = 1'b1; SRAM_ADDR = '0; SRAM_WDATA = '0; SRAM_WEn = 1'b1; SRAM_WBEn = 8'hFF;
        for (int i = 0; i < DEPTH; i++) known[i] = 1'b0;

        repeat (3) @(negedge CLK);
        check("rst PRDATA", 64'(PRDATA), 64'd0);
        check("rst SRAM_RDATA", SRAM_RDATA, 64'd0);
        check("rst IRQ", 64'(IRQ), 64'd0);
        check("rst START_OUT", 64'(START_OUT), 64'd0);
        check("rst DONE_OUT", 64'(DONE_OUT), 64'd0);
        check("rst PREADY", 64'(PREADY), 64'd1);
        RESETn = 1'b1;

        vecs[0]  = '{1'b0, 32'h000, 32'h0,         32'h5A5A_5A5A};
        vecs[1]  = '{1'b0, 32'h004, 32'h0,         32'h0};
        vecs[2]  = '{1'b0, 32'h008, 32'h0,         32'h0};
        vecs[3]  = '{1'b0, 32'h00C, 32'h0,         32'h0};
        vecs[4]  = '{1'b0, 32'h010, 32'h0,         32'h0};
        vecs[5]  = '{1'b0, 32'h014, 32'h0,         32'h0};
        vecs[6]  = '{1'b0, 32'hFFC, 32'h0,         32'h0};
        vecs[7]  = '{1'b1, 32'h00C, 32'h1FF,       32'h1FF};
        vecs[8]  = '{1'b1, 32'h00C, 32'hFFFF_FE05, 32'h005};
        vecs[9]  = '{1'b1, 32'h004, 32'h2,         32'h2};
        vecs[10] = '{1'b1, 32'h004, 32'h0,         32'h0};
        vecs[11] = '{1'b1, 32'h000, 32'h0,         32'h5A5A_5A5A};
        vecs[12] = '{1'b1, 32'h010, 32'h1234,      32'h0};
        vecs[13] = '{1'b1, 32'h008, 32'h7,         32'h0};
        for (int i = 0; i < 14; i++) begin
            if (vecs[i].wr) begin
                apb_write(vecs[i].addr, vecs[i].data, err);
                check($sformatf("vec%0d pslverr", i), 64'(err), 64'd0);
            end
            apb_read(vecs[i].addr, rd);
            check($sformatf("vec%0d reg %h", i, vecs[i].addr), 64'(rd), 64'(vecs[i].exp));
        end

        // Byte-masked write
        model_sram_write(0, 3, 64'h1111_2222_3333_4444, 8'h00);
        model_sram_write(0, 3, 64'hFFFF_FFFF_FFFF_FFFF, 8'hF0);
        sram_read(0, 3, d);
        check("bytemask A[3]", d, 64'h1111_2222_FFFF_FFFF);
        @(negedge CLK);
        check("rdata hold", SRAM_RDATA, 64'h1111_2222_FFFF_FFFF);

        // Multi-word carry
        model_sram_write(0, 0, '1, 8'h00);
        model_sram_write(0, 1, '0, 8'h00);
        model_sram_write(1, 0, 64'd1, 8'h00);
        model_sram_write(1, 1, '0, 8'h00);
        do_run(32'd2, 1'b1, "carry2");
        check("carry2 R0", mr[0], 64'd0);
        check("carry2 R1", mr[1], 64'd1);
        apb_write(32'h008, 32'h2, err);
        check("w1c irq", 64'(IRQ), 64'd0);
        apb_read(32'h008, rd);
        check("w1c status", 64'(rd), 64'd0);

        // Final carry and clamp
        for (int i = 0; i < DEPTH; i++) begin
            model_sram_write(0, i, '1, 8'h00);
            model_sram_write(1, i, 64'd1, 8'h00);
        end
        do_run(32'd0, 1'b0, "clamp");

        // Busy protection
        void'(model_run(16));
        apb_write(32'h00C, 32'd16, err);
        s0 = start_cnt; d0 = done_cnt;
        apb_write(32'h004, 32'h1, err);
        apb_write(32'h004, 32'h1, err);
        check("busy start pslverr", 64'(err), 64'd1);
        sram_write(0, 0, 64'd5, 8'h00);
        apb_write(32'h00C, 32'd7, err);
        check("busy len pslverr", 64'(err), 64'd0);
        wait_done(d0, "busy");
        repeat (40) @(negedge CLK);
        check("busy one done", 64'(done_cnt - d0), 64'd1);
        check("busy one start", 64'(start_cnt - s0), 64'd1);
        apb_read(32'h00C, rd);
        check("busy len kept", 64'(rd), 64'd16);
        sram_read(0, 0, d);
        check("busy A0 kept", d, ma[0]);
        check_r("busy");

        // Reset mid-run
        apb_write(32'h00C, 32'd8, err);
        d0 = done_cnt;
        apb_write(32'h004, 32'h3, err);
        RESETn = 1'b0;
        repeat (2) @(negedge CLK);
        RESETn = 1'b1;
        check("rstrun irq", 64'(IRQ), 64'd0);
        apb_read(32'h008, rd);
        check("rstrun status", 64'(rd), 64'd0);
        repeat (30) @(negedge CLK);
        check("rstrun no done", 64'(done_cnt - d0), 64'd0);
        do_run(32'd8, 1'b1, "post_rst");

        // Randomized operands and lengths
        for (int it = 0; it < 6; it++) begin
            int          bank, word;
            logic [63:0] rv;
            for (int k = 0; k < 24; k++) begin
                bank = $urandom_range(0, 3);
                word = $urandom_range(0, DEPTH - 1);
                rv = {$urandom, $urandom};
                model_sram_write(bank, word, rv, 8'($urandom));
            end
            word = $urandom_range(0, DEPTH - 1);
            sram_read(0, word, d);
            check("rand A", d, ma[word]);
            sram_read(1, word, d);
            check("rand B", d, mb[word]);
            sram_read(3, word, d);
            check("rand bank3", d, 64'd0);
            do_run(32'($urandom_range(0, 40)), it[0], $sformatf("rand%0d", it));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
